// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction RAM sharing between program loader and fetch sequencer
module imem_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int DEPTH = 128,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              ld_req,
    output logic              ld_err,
    input  logic              fetch_en,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [WORD_W-1:0] mem_data_in,
    input  logic [WORD_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

    localparam logic [WORD_W-1:0] NOP = WORD_W'(32'h0000_0013);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              ld_err_q, ld_err_d;

    logic [ADDR_W-1:0] ld_idx, pc_idx, target_al;
    logic              ld_in_range, pc_in_range;

    assign ld_idx      = ld_addr >> 2;
    assign pc_idx      = pc_q >> 2;
    assign ld_in_range = ld_idx < ADDR_W'(DEPTH);
    assign pc_in_range = pc_idx < ADDR_W'(DEPTH);
    assign target_al   = jump_target & ~ADDR_W'(3);

    assign mem_data_in = ld_data;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign ld_err      = ld_err_q;

    // RAM strobes are combinational so a load write or fetch read lands in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        ld_err_d     = ld_err_q;
        ld_ready     = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = '0;
        if (!rst) begin
            case (state_q)
                S_LOAD: begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        if (ld_in_range) begin
                            mem_wr_en = 1'b1;
                            mem_addr  = ld_idx;
                        end else begin
                            ld_err_d = 1'b1;
                        end
                    end
                    if (ld_done) begin
                        pc_d    = RESET_PC;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ld_req) begin
                        state_d = S_LOAD;
                    end else if (jump) begin
                        pc_d = target_al;
                    end else if (fetch_en) begin
                        state_d = S_CAPTURE;
                        if (pc_in_range) begin
                            mem_rd_en = 1'b1;
                            mem_addr  = pc_idx;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (jump) begin
                        pc_d    = target_al;
                        state_d = S_ISSUE;
                    end else begin
                        // pc is unchanged since ISSUE, so the range check still matches the read.
                        inst_d       = pc_in_range ? mem_data_out : NOP;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready || jump) begin
                        inst_valid_d = 1'b0;
                        pc_d         = jump ? target_al : pc_q + ADDR_W'(4);
                        state_d      = S_ISSUE;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            ld_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            ld_err_q     <= ld_err_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam int DEPTH = 128;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0, ld_done = 1'b0, ld_req = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;
    logic        fetch_en = 1'b0, jump = 1'b0, inst_ready = 1'b0;
    logic [31:0] jump_target = '0;
    logic        ld_ready, ld_err, inst_valid, mem_rd_en, mem_wr_en;
    logic [31:0] inst, inst_pc, mem_addr, mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] ram [DEPTH];
    logic [31:0] mdl [DEPTH];
    logic [63:0] exp_q [$];

    int n_checks = 0;
    int n_fail = 0;

    imem_fetch_ctrl #(.ADDR_W(32), .WORD_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_req(ld_req), .ld_err(ld_err),
        .fetch_en(fetch_en), .jump(jump), .jump_target(jump_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr[6:0]] <= mem_data_in;
        if (mem_rd_en) mem_data_out <= ram[mem_addr[6:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted instruction and polices the strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_inst_pc", {32'h0, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("inst", {32'h0, inst}, {32'h0, e[31:0]});
                    chk("inst_pc", {32'h0, inst_pc}, {32'h0, e[63:32]});
                end
            end
            if (mem_rd_en || mem_wr_en)
                chk("strobe_exclusive", {63'h0, mem_rd_en & mem_wr_en}, 64'h0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        return (idx < DEPTH) ? mdl[idx[6:0]] : NOP;
    endfunction

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input logic done);
        logic [31:0] idx;
        logic        in_range;
        idx = addr >> 2;
        in_range = idx < DEPTH;
        ld_valid = 1'b1; ld_addr = addr; ld_data = data; ld_done = done;
        @(negedge clk);
        chk("ld_wr_en", {63'h0, mem_wr_en}, {63'h0, in_range});
        if (in_range) begin
            chk("ld_mem_addr", {32'h0, mem_addr}, {32'h0, idx});
            chk("ld_mem_data", {32'h0, mem_data_in}, {32'h0, data});
            mdl[idx[6:0]] = data;
        end
        tick;
        ld_valid = 1'b0; ld_done = 1'b0;
    endtask

    // Starts in ISSUE; one full ISSUE -> CAPTURE -> HOLD -> ISSUE pass with the consumer ready.
    task automatic fetch_one(input logic [31:0] pc);
        logic in_range;
        in_range = (pc >> 2) < DEPTH;
        exp_q.push_back({pc, exp_word(pc)});
        fetch_en = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        chk("fetch_rd_en", {63'h0, mem_rd_en}, {63'h0, in_range});
        if (in_range) chk("fetch_mem_addr", {32'h0, mem_addr}, {32'h0, pc >> 2});
        tick;
        fetch_en = 1'b0;
        @(negedge clk);
        chk("capture_valid", {63'h0, inst_valid}, 64'h0);
        tick;
        @(negedge clk);
        chk("hold_valid", {63'h0, inst_valid}, 64'h1);
        tick;
    endtask

    initial begin
        int cnt;
        // Reset state
        tick; tick;
        @(negedge clk);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
        chk("rst_ld_err", {63'h0, ld_err}, 64'h0);
        chk("rst_strobes", {62'h0, mem_rd_en, mem_wr_en}, 64'h0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("load_ld_ready", {63'h0, ld_ready}, 64'h1);
        tick;

        // T1: load and stream three words
        load_word(32'h0, 32'h0050_0093, 1'b0);
        load_word(32'h4, 32'h0010_0113, 1'b0);
        load_word(32'h8, 32'h0020_81b3, 1'b0);
        load_word(32'hC, 32'h4020_8233, 1'b0);
        load_word(32'h10, 32'h0042_8293, 1'b0);
        ld_done = 1'b1; tick; ld_done = 1'b0;
        exp_q.push_back({32'h0, 32'h0050_0093});
        exp_q.push_back({32'h4, 32'h0010_0113});
        exp_q.push_back({32'h8, 32'h0020_81b3});
        fetch_en = 1'b1; inst_ready = 1'b1;
        @(negedge clk); chk("t1_lat0", {63'h0, inst_valid}, 64'h0); tick;
        @(negedge clk); chk("t1_lat1", {63'h0, inst_valid}, 64'h0); tick;
        @(negedge clk); chk("t1_lat2", {63'h0, inst_valid}, 64'h1); tick;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 30) begin
            tick;
            cnt++;
        end
        fetch_en = 1'b0;
        chk("t1_drain_timeout", {63'h0, cnt >= 30}, 64'h0);

        // T2: backpressure in HOLD at pc 0xC
        exp_q.push_back({32'hC, 32'h4020_8233});
        fetch_en = 1'b1; inst_ready = 1'b0;
        tick; fetch_en = 1'b0; tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_valid", {63'h0, inst_valid}, 64'h1);
            chk("t2_inst", {32'h0, inst}, {32'h0, 32'h4020_8233});
            chk("t2_inst_pc", {32'h0, inst_pc}, 64'hC);
            chk("t2_rd_en", {63'h0, mem_rd_en}, 64'h0);
            tick;
        end
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;

        // T3a: jump with ready in HOLD
        exp_q.push_back({32'h10, 32'h0042_8293});
        fetch_en = 1'b1; tick; fetch_en = 1'b0; tick;
        jump = 1'b1; jump_target = 32'h8; inst_ready = 1'b1;
        tick;
        jump = 1'b0;
        fetch_one(32'h8);

        // T3b: jump in CAPTURE squashes; misaligned target rounds down
        fetch_en = 1'b1; tick; fetch_en = 1'b0;
        jump = 1'b1; jump_target = 32'h6;
        tick;
        jump = 1'b0;
        @(negedge clk);
        chk("t3_squash_valid", {63'h0, inst_valid}, 64'h0);
        tick;
        fetch_one(32'h4);

        // T6b: ld_req beats jump in ISSUE
        ld_req = 1'b1; jump = 1'b1; jump_target = 32'h40;
        tick;
        ld_req = 1'b0; jump = 1'b0;
        @(negedge clk);
        chk("t6_ld_ready", {63'h0, ld_ready}, 64'h1);
        tick;

        // T4: out-of-range load
        load_word(32'h200, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("t4_ld_err", {63'h0, ld_err}, 64'h1);
        tick;

        // T6a: write and done together, then fetch at RESET_PC
        load_word(32'h0, 32'h1234_5678, 1'b1);
        fetch_one(32'h0);

        // T4: out-of-range fetch substitutes NOP; pc wrap
        jump = 1'b1; jump_target = 32'h200; tick; jump = 1'b0;
        fetch_one(32'h200);
        jump = 1'b1; jump_target = 32'hFFFF_FFFC; tick; jump = 1'b0;
        fetch_one(32'hFFFF_FFFC);
        fetch_one(32'h0);

        // T5: reset while holding an instruction
        fetch_en = 1'b1; inst_ready = 1'b0; tick; fetch_en = 1'b0; tick;
        rst = 1'b1; tick; rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", {63'h0, inst_valid}, 64'h0);
        chk("t5_ld_ready", {63'h0, ld_ready}, 64'h1);
        tick;
        ld_done = 1'b1; tick; ld_done = 1'b0;
        fetch_one(32'h0);

        tick; tick;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
